// File: rtl/flag_cond_unit_pkg.sv
// Shared types and constants for the flag/condition unit: branch op encoding,
// ARM condition codes, FSM states and NZCV bit positions.
package cond_pkg;

   typedef enum logic [1:0] {
      OP_B     = 2'd0,
      OP_BCOND = 2'd1,
      OP_CBZ   = 2'd2,
      OP_CBNZ  = 2'd3
   } cond_op_t;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_HS = 4'd2;
   localparam logic [3:0] COND_LO = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } fsm_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational ARM condition-code evaluator over an {N,Z,C,V} vector.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] nzcv,
   input  logic [3:0] code,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      n    = nzcv[FLAG_N];
      z    = nzcv[FLAG_Z];
      c    = nzcv[FLAG_C];
      v    = nzcv[FLAG_V];
      pass = 1'b1;
      case (code)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_HS: pass = c;
         COND_LO: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         default: pass = 1'b1;  // AL and NV both always pass
      endcase
   end

endmodule

// File: rtl/flag_cond_unit.sv
// NZCV register, in-flight flag-writer tracking and branch decision handshake.
// Optional macro FLAG_FWD_EN: let B.cond consume the last writer's flags in its retire cycle.
module flag_cond_unit
   import cond_pkg::*;
#(
   parameter int MAX_PEND = 3,
   parameter int DATA_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_setflags,
   output logic              issue_ready,
   input  logic              alu_valid,
   input  logic              set_flags,
   input  logic              alu_negative,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   input  logic              alu_carry_out,
   input  logic              cond_valid,
   output logic              cond_ready,
   input  logic [1:0]        cond_op,
   input  logic [3:0]        cond_code,
   input  logic [DATA_W-1:0] cbz_value,
   output logic              taken_valid,
   output logic              taken,
   input  logic              taken_ready,
   output logic [3:0]        flags
);

   localparam int PW = $clog2(MAX_PEND + 1);

   logic [3:0]    flags_q, flags_d;
   logic [PW-1:0] pend_q, pend_d;
   fsm_state_t    state_q, state_d;
   logic          taken_q, taken_d;

   logic          retire;
   logic [3:0]    alu_nzcv;
   logic [3:0]    eval_flags;
   logic          is_bcond;
   logic          blk;
   logic          accept;
   logic          cond_pass;
   logic          decision;

   assign retire   = alu_valid & set_flags;
   assign alu_nzcv = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
   assign is_bcond = (cond_op_t'(cond_op) == OP_BCOND);

`ifdef FLAG_FWD_EN
   logic fwd;
   // Last outstanding writer retiring with nothing new behind it: its flags are final.
   assign fwd        = (pend_q == PW'(1)) & retire & ~issue_setflags;
   assign blk        = is_bcond & (pend_q != '0) & ~fwd;
   assign eval_flags = fwd ? alu_nzcv : flags_q;
`else
   assign blk        = is_bcond & (pend_q != '0);
   assign eval_flags = flags_q;
`endif

   cond_eval u_cond_eval (
      .nzcv (eval_flags),
      .code (cond_code),
      .pass (cond_pass)
   );

   assign taken_valid = (state_q == RESP);
   assign taken       = taken_q;
   assign flags       = flags_q;
   assign issue_ready = (pend_q != PW'(MAX_PEND));
   assign cond_ready  = ~blk & (~taken_valid | taken_ready);
   assign accept      = cond_valid & cond_ready;

   always_comb begin
      decision = 1'b1;
      case (cond_op_t'(cond_op))
         OP_B:     decision = 1'b1;
         OP_BCOND: decision = cond_pass;
         OP_CBZ:   decision = (cbz_value == '0);
         OP_CBNZ:  decision = (cbz_value != '0);
         default:  decision = 1'b1;
      endcase
   end

   always_comb begin
      flags_d = flags_q;
      pend_d  = pend_q;
      state_d = state_q;
      taken_d = taken_q;

      if (retire) flags_d = alu_nzcv;

      // A retire with nothing outstanding only updates the flags.
      if (issue_setflags & ~retire & (pend_q != PW'(MAX_PEND)))
         pend_d = pend_q + PW'(1);
      else if (retire & ~issue_setflags & (pend_q != '0))
         pend_d = pend_q - PW'(1);

      if (accept) taken_d = decision;

      case (state_q)
         IDLE: if (accept) state_d = RESP;
         RESP: if (taken_ready) state_d = accept ? RESP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= 4'b0000;
         pend_q  <= '0;
         state_q <= IDLE;
         taken_q <= 1'b0;
      end else begin
         flags_q <= flags_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         taken_q <= taken_d;
      end
   end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: table of flag/branch vectors plus hand sequences.
module tb_flag_cond_unit;
   import cond_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        issue_setflags = 1'b0;
   logic        issue_ready;
   logic        alu_valid = 1'b0;
   logic        set_flags = 1'b0;
   logic        alu_negative = 1'b0;
   logic        alu_zero = 1'b0;
   logic        alu_overflow = 1'b0;
   logic        alu_carry_out = 1'b0;
   logic        cond_valid = 1'b0;
   logic        cond_ready;
   logic [1:0]  cond_op = 2'd0;
   logic [3:0]  cond_code = 4'd0;
   logic [63:0] cbz_value = 64'd0;
   logic        taken_valid;
   logic        taken;
   logic        taken_ready = 1'b1;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   flag_cond_unit #(.MAX_PEND(3), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .issue_setflags(issue_setflags), .issue_ready(issue_ready),
      .alu_valid(alu_valid), .set_flags(set_flags),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
      .cond_valid(cond_valid), .cond_ready(cond_ready),
      .cond_op(cond_op), .cond_code(cond_code), .cbz_value(cbz_value),
      .taken_valid(taken_valid), .taken(taken), .taken_ready(taken_ready),
      .flags(flags)
   );

   typedef struct {
      logic [3:0]  nzcv;
      logic [1:0]  op;
      logic [3:0]  code;
      logic [63:0] val;
      logic        exp_taken;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic [3:0] nzcv);
      alu_valid     = 1'b1;
      set_flags     = 1'b1;
      alu_negative  = nzcv[3];
      alu_zero      = nzcv[2];
      alu_carry_out = nzcv[1];
      alu_overflow  = nzcv[0];
   endtask

   task automatic drive_req(input logic [1:0] op, input logic [3:0] code, input logic [63:0] val);
      cond_valid = 1'b1;
      cond_op    = op;
      cond_code  = code;
      cbz_value  = val;
   endtask

   initial begin
      vecs[0]  = '{4'b0110, OP_BCOND, COND_EQ, 64'd0, 1'b1};
      vecs[1]  = '{4'b0110, OP_BCOND, COND_NE, 64'd0, 1'b0};
      vecs[2]  = '{4'b0110, OP_BCOND, COND_HS, 64'd0, 1'b1};
      vecs[3]  = '{4'b0110, OP_BCOND, COND_HI, 64'd0, 1'b0};
      vecs[4]  = '{4'b0110, OP_BCOND, COND_LS, 64'd0, 1'b1};
      vecs[5]  = '{4'b0110, OP_BCOND, COND_GE, 64'd0, 1'b1};
      vecs[6]  = '{4'b0110, OP_BCOND, COND_GT, 64'd0, 1'b0};
      vecs[7]  = '{4'b0110, OP_BCOND, COND_LE, 64'd0, 1'b1};
      vecs[8]  = '{4'b1001, OP_BCOND, COND_MI, 64'd0, 1'b1};
      vecs[9]  = '{4'b1001, OP_BCOND, COND_PL, 64'd0, 1'b0};
      vecs[10] = '{4'b1001, OP_BCOND, COND_VS, 64'd0, 1'b1};
      vecs[11] = '{4'b1001, OP_BCOND, COND_VC, 64'd0, 1'b0};
      vecs[12] = '{4'b1001, OP_BCOND, COND_GT, 64'd0, 1'b1};
      vecs[13] = '{4'b1001, OP_BCOND, COND_LO, 64'd0, 1'b1};
      vecs[14] = '{4'b1000, OP_BCOND, COND_LT, 64'd0, 1'b1};
      vecs[15] = '{4'b1000, OP_BCOND, COND_GE, 64'd0, 1'b0};
      vecs[16] = '{4'b1000, OP_BCOND, COND_NV, 64'd0, 1'b1};
      vecs[17] = '{4'b0000, OP_CBZ,   COND_EQ, 64'd0, 1'b1};
      vecs[18] = '{4'b0000, OP_CBZ,   COND_EQ, 64'd5, 1'b0};
      vecs[19] = '{4'b0000, OP_CBNZ,  COND_EQ, 64'd0, 1'b0};
      vecs[20] = '{4'b0000, OP_CBNZ,  COND_EQ, 64'h8000_0000_0000_0000, 1'b1};
      vecs[21] = '{4'b0100, OP_B,     COND_NE, 64'd0, 1'b1};

      // Reset state
      #12;
      chk("rst_flags", {60'd0, flags}, 64'h0);
      chk("rst_taken_valid", {63'd0, taken_valid}, 64'h0);
      step();
      reset = 1'b0;
      #1;
      chk("rst_cond_ready", {63'd0, cond_ready}, 64'h1);
      chk("rst_issue_ready", {63'd0, issue_ready}, 64'h1);

      // Table: write flags, then issue one request and check its decision
      for (int i = 0; i < NV; i++) begin
         step();
         drive_alu(vecs[i].nzcv);
         step();
         alu_valid = 1'b0;
         set_flags = 1'b0;
         chk("vec_flags", {60'd0, flags}, {60'd0, vecs[i].nzcv});
         drive_req(vecs[i].op, vecs[i].code, vecs[i].val);
         #1;
         chk("vec_cond_ready", {63'd0, cond_ready}, 64'h1);
         step();
         cond_valid = 1'b0;
         chk("vec_taken_valid", {63'd0, taken_valid}, 64'h1);
         chk("vec_taken", {63'd0, taken}, {63'd0, vecs[i].exp_taken});
         $display("vec %0d nzcv=%b op=%0d code=%0d val=%0h taken=%b exp=%b",
                  i, vecs[i].nzcv, vecs[i].op, vecs[i].code, vecs[i].val, taken, vecs[i].exp_taken);
         step();
         chk("vec_idle", {63'd0, taken_valid}, 64'h0);
      end

      // Flag write and BCOND accept in the same cycle: decision uses old flags (0100 -> EQ taken)
      step();
      drive_alu(4'b0100);
      step();
      drive_alu(4'b0000);
      drive_req(OP_BCOND, COND_EQ, 64'd0);
      step();
      alu_valid = 1'b0; set_flags = 1'b0; cond_valid = 1'b0;
      chk("same_cycle_old_flags", {63'd0, taken}, 64'h1);
      chk("same_cycle_new_flags", {60'd0, flags}, 64'h0);
      $display("txn same-cycle flag write + BCOND EQ taken=%b", taken);
      step();

      // BCOND GT waits for an in-flight writer; prior flags Z=1 make GT false
      drive_alu(4'b0100);
      step();
      alu_valid = 1'b0; set_flags = 1'b0;
      issue_setflags = 1'b1;
      step();
      issue_setflags = 1'b0;
      drive_req(OP_BCOND, COND_GT, 64'd0);
      #1;
      chk("wait_blocked0", {63'd0, cond_ready}, 64'h0);
      step();
      chk("wait_blocked1", {63'd0, cond_ready}, 64'h0);
      drive_alu(4'b0000);
      #1;
`ifdef FLAG_FWD_EN
      chk("wait_retire_ready", {63'd0, cond_ready}, 64'h1);
      step();
      alu_valid = 1'b0; set_flags = 1'b0; cond_valid = 1'b0;
`else
      chk("wait_retire_ready", {63'd0, cond_ready}, 64'h0);
      step();
      alu_valid = 1'b0; set_flags = 1'b0;
      chk("wait_no_early", {63'd0, taken_valid}, 64'h0);
      chk("wait_after_ready", {63'd0, cond_ready}, 64'h1);
      step();
      cond_valid = 1'b0;
`endif
      chk("wait_taken_valid", {63'd0, taken_valid}, 64'h1);
      chk("wait_taken", {63'd0, taken}, 64'h1);
      $display("txn BCOND GT after writer retire taken=%b", taken);
      step();

      // Back-to-back CBZ(0), CBNZ(0), B
      drive_req(OP_CBZ, 4'd0, 64'd0);
      step();
      drive_req(OP_CBNZ, 4'd0, 64'd0);
      chk("b2b_0", {62'd0, taken_valid, taken}, 64'h3);
      step();
      drive_req(OP_B, 4'd0, 64'd0);
      chk("b2b_1", {62'd0, taken_valid, taken}, 64'h2);
      step();
      cond_valid = 1'b0;
      chk("b2b_2", {62'd0, taken_valid, taken}, 64'h3);
      step();
      chk("b2b_idle", {63'd0, taken_valid}, 64'h0);
      $display("txn back-to-back CBZ/CBNZ/B done");

      // Backpressure: hold decision for 3 cycles, queued CBZ(5) goes on release
      taken_ready = 1'b0;
      drive_req(OP_B, 4'd0, 64'd0);
      step();
      drive_req(OP_CBZ, 4'd0, 64'd5);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_hold", {61'd0, taken_valid, taken, cond_ready}, 64'h6);
         step();
      end
      taken_ready = 1'b1;
      #1;
      chk("bp_release_ready", {63'd0, cond_ready}, 64'h1);
      step();
      cond_valid = 1'b0;
      chk("bp_queued", {62'd0, taken_valid, taken}, 64'h2);
      step();
      chk("bp_idle", {63'd0, taken_valid}, 64'h0);
      $display("txn backpressure release taken=%b", taken);

      // Pending counter limits; BCOND on cond_op probes blocking with cond_valid low
      cond_op = OP_BCOND;
      cond_code = COND_AL;
      issue_setflags = 1'b1;
      step(); step(); step();
      chk("pend3_issue_ready", {63'd0, issue_ready}, 64'h0);
      chk("pend3_blk", {63'd0, cond_ready}, 64'h0);
      drive_alu(4'b0010);
      step();
      issue_setflags = 1'b0;
      alu_valid = 1'b0; set_flags = 1'b0;
      chk("pend3_both", {63'd0, issue_ready}, 64'h0);
      drive_alu(4'b0010);
      step();
      alu_valid = 1'b0; set_flags = 1'b0;
      chk("pend2_issue_ready", {63'd0, issue_ready}, 64'h1);
      chk("pend2_blk", {63'd0, cond_ready}, 64'h0);
      drive_alu(4'b0010);
      step();
      drive_alu(4'b0010);
      step();
      alu_valid = 1'b0; set_flags = 1'b0;
      chk("pend0_unblk", {63'd0, cond_ready}, 64'h1);
      drive_alu(4'b1111);
      step();
      alu_valid = 1'b0; set_flags = 1'b0;
      chk("underflow_flags", {60'd0, flags}, 64'hF);
      chk("underflow_unblk", {63'd0, cond_ready}, 64'h1);
      chk("underflow_issue_ready", {63'd0, issue_ready}, 64'h1);
      $display("txn pend counter limits flags=%b", flags);

      // Reset mid-RESP: valid and flags drop without a clock edge
      taken_ready = 1'b0;
      drive_req(OP_B, 4'd0, 64'd0);
      step();
      cond_valid = 1'b0;
      chk("pre_rst_valid", {63'd0, taken_valid}, 64'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, taken_valid}, 64'h0);
      chk("async_rst_flags", {60'd0, flags}, 64'h0);
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_cond_ready", {63'd0, cond_ready}, 64'h1);
      chk("post_rst_issue_ready", {63'd0, issue_ready}, 64'h1);
      $display("txn async reset mid-RESP");
      taken_ready = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
